// File: rtl/seq_divider.sv
// seq_divider
//   Multi-cycle unsigned restoring divider. It produces one quotient bit per
//   clock and sits beside the single-cycle ALU as the long-latency execute
//   unit. The pipeline controller drives it through a start/busy/done
//   handshake.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; results from the last operation are held
//   CALC  | one subtract-and-compare step per cycle, WIDTH steps in total
//   DONE  | done pulse cycle; a new start here is accepted with no gap
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while not busy
//   dividend   unsigned numerator, captured with an accepted start
//   divisor    unsigned denominator, captured with an accepted start
//   busy       high while a division is in progress
//   done       one-cycle pulse, results valid
//   quotient   registered quotient (all ones on divide-by-zero)
//   remainder  registered remainder (dividend on divide-by-zero)
//   div_zero   registered divide-by-zero flag, held with the results
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] dvsr_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             q_bit;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] q_next;

  // The partial remainder is always below the divisor after a step. Its top
  // bit therefore never reaches the shifted value, so it is not read.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_r[WIDTH];

  // T = shifted - divisor, formed as shifted + ~divisor + 1 over WIDTH+1
  // bits. Bit WIDTH+1 is the carry out: it is set exactly when shifted is at
  // least the divisor, which means the subtraction did not borrow.
  assign shifted  = {rem_r[WIDTH-1:0], q_r[WIDTH-1]};
  assign diff     = {1'b0, shifted} + {1'b0, ~{1'b0, dvsr_r}} + (WIDTH+2)'(1);
  assign q_bit    = diff[WIDTH+1];
  assign rem_next = q_bit ? diff[WIDTH:0] : shifted;
  assign q_next   = {q_r[WIDTH-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      cnt       <= '0;
      rem_r     <= '0;
      q_r       <= '0;
      dvsr_r    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            dvsr_r <= divisor;
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              cnt   <= CW'(WIDTH - 1);
              rem_r <= '0;
              q_r   <= dividend;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem_r <= rem_next;
          q_r   <= q_next;
          if (cnt == '0) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= rem_next[WIDTH-1:0];
            div_zero  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a start request and return 1 time unit after the accepting edge.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called just after the accepting edge. Negedge i samples the state after
  // edge k+i. It returns the i where done is seen, or -1 if the bound runs
  // out. When poke_at >= 0 it drives a start with 9/3 for one cycle at that
  // sample; that start lands on an edge where the divider is busy.
  task automatic wait_done(input int poke_at, output int n, output int busy_cnt,
                           output bit overlap);
    n = -1;
    busy_cnt = 0;
    overlap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == poke_at + 1) start = 1'b0;
      if (busy && done) overlap = 1'b1;
      if (busy) busy_cnt++;
      if (done) begin
        n = i;
        break;
      end
      if (i == poke_at) begin
        dividend = 16'd9;
        divisor  = 16'd3;
        start    = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #3 rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total_cnt++; if (quotient !== '0) $display("FAIL reset_quot got %h want 0", quotient); else pass_cnt++;
    total_cnt++; if (remainder !== '0) $display("FAIL reset_rem got %h want 0", remainder); else pass_cnt++;
    total_cnt++; if (div_zero !== 1'b0) $display("FAIL reset_dz got %b want 0", div_zero); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] va [4] = '{16'd100, 16'hFFFF, 16'hFFFF, 16'd3};
    logic [WIDTH-1:0] vb [4] = '{16'd7,   16'd1,    16'hFFFF, 16'd10};
    logic [WIDTH-1:0] eq [4] = '{16'd14,  16'hFFFF, 16'd1,    16'd0};
    logic [WIDTH-1:0] er [4] = '{16'd2,   16'd0,    16'd0,    16'd3};
    int n, bc;
    bit ov;
    for (int v = 0; v < 4; v++) begin
      launch(va[v], vb[v]);
      wait_done(-1, n, bc, ov);
      total_cnt++; if (n !== WIDTH) $display("FAIL dir%0d_latency got %0d want %0d", v, n, WIDTH); else pass_cnt++;
      total_cnt++; if (bc !== WIDTH) $display("FAIL dir%0d_busy_cycles got %0d want %0d", v, bc, WIDTH); else pass_cnt++;
      total_cnt++; if (ov !== 1'b0) $display("FAIL dir%0d_busy_done_overlap got 1 want 0", v); else pass_cnt++;
      total_cnt++; if (quotient !== eq[v]) $display("FAIL dir%0d_quot got %h want %h", v, quotient, eq[v]); else pass_cnt++;
      total_cnt++; if (remainder !== er[v]) $display("FAIL dir%0d_rem got %h want %h", v, remainder, er[v]); else pass_cnt++;
      total_cnt++; if (div_zero !== 1'b0) $display("FAIL dir%0d_dz got %b want 0", v, div_zero); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (done !== 1'b0) $display("FAIL dir%0d_done_width got %b want 0", v, done); else pass_cnt++;
    end
  endtask

  task automatic test_div_zero();
    int n, bc;
    bit ov;
    launch(16'd5, 16'd0);
    wait_done(-1, n, bc, ov);
    total_cnt++; if (n !== 0) $display("FAIL dz_latency got %0d want 0", n); else pass_cnt++;
    total_cnt++; if (bc !== 0) $display("FAIL dz_busy_cycles got %0d want 0", bc); else pass_cnt++;
    total_cnt++; if (div_zero !== 1'b1) $display("FAIL dz_flag got %b want 1", div_zero); else pass_cnt++;
    total_cnt++; if (quotient !== 16'hFFFF) $display("FAIL dz_quot got %h want ffff", quotient); else pass_cnt++;
    total_cnt++; if (remainder !== 16'd5) $display("FAIL dz_rem got %h want 0005", remainder); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0) $display("FAIL dz_done_width got %b want 0", done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL dz_busy_after got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (div_zero !== 1'b1) $display("FAIL dz_flag_held got %b want 1", div_zero); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n, bc;
    bit ov;
    launch(16'd100, 16'd7);
    wait_done(4, n, bc, ov);
    total_cnt++; if (n !== WIDTH) $display("FAIL ign_latency got %0d want %0d", n, WIDTH); else pass_cnt++;
    total_cnt++; if (quotient !== 16'd14) $display("FAIL ign_quot got %0d want 14", quotient); else pass_cnt++;
    total_cnt++; if (remainder !== 16'd2) $display("FAIL ign_rem got %0d want 2", remainder); else pass_cnt++;
    // Still in the DONE cycle: a start here must be accepted at the next edge.
    dividend = 16'd9;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (quotient !== 16'd14) $display("FAIL b2b_quot_held got %0d want 14", quotient); else pass_cnt++;
    wait_done(-1, n, bc, ov);
    total_cnt++; if (n !== WIDTH) $display("FAIL b2b_latency got %0d want %0d", n, WIDTH); else pass_cnt++;
    total_cnt++; if (ov !== 1'b0) $display("FAIL b2b_overlap got 1 want 0"); else pass_cnt++;
    total_cnt++; if (quotient !== 16'd3) $display("FAIL b2b_quot got %0d want 3", quotient); else pass_cnt++;
    total_cnt++; if (remainder !== 16'd0) $display("FAIL b2b_rem got %0d want 0", remainder); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n, bc;
    bit ov;
    bit saw_done;
    launch(16'd100, 16'd7);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rmid_done got %b want 0", done); else pass_cnt++;
    total_cnt++; if (quotient !== '0) $display("FAIL rmid_quot got %h want 0", quotient); else pass_cnt++;
    total_cnt++; if (remainder !== '0) $display("FAIL rmid_rem got %h want 0", remainder); else pass_cnt++;
    total_cnt++; if (div_zero !== 1'b0) $display("FAIL rmid_dz got %b want 0", div_zero); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    total_cnt++; if (saw_done !== 1'b0) $display("FAIL rmid_no_done got 1 want 0"); else pass_cnt++;
    launch(16'd50, 16'd5);
    wait_done(-1, n, bc, ov);
    total_cnt++; if (n !== WIDTH) $display("FAIL rmid_latency got %0d want %0d", n, WIDTH); else pass_cnt++;
    total_cnt++; if (quotient !== 16'd10) $display("FAIL rmid_quot2 got %0d want 10", quotient); else pass_cnt++;
    total_cnt++; if (remainder !== 16'd0) $display("FAIL rmid_rem2 got %0d want 0", remainder); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b, exp_q, exp_r;
    int n, bc, exp_n;
    bit ov;
    for (int i = 0; i < 1000; i++) begin
      a = WIDTH'($urandom_range(0, 65535));
      if (i % 16 == 0)     b = '0;
      else if (i % 4 == 1) b = WIDTH'($urandom_range(1, 15));
      else                 b = WIDTH'($urandom_range(1, 65535));
      if (b == '0) begin
        exp_q = 16'hFFFF; exp_r = a; exp_n = 0;
      end else begin
        exp_q = a / b; exp_r = a % b; exp_n = WIDTH;
      end
      launch(a, b);
      wait_done(-1, n, bc, ov);
      total_cnt++; if (n !== exp_n || ov) $display("FAIL rnd%0d_timing got lat %0d ovl %b want %0d 0", i, n, ov, exp_n); else pass_cnt++;
      total_cnt++; if (quotient !== exp_q) $display("FAIL rnd%0d_quot %h/%h got %h want %h", i, a, b, quotient, exp_q); else pass_cnt++;
      total_cnt++; if (remainder !== exp_r) $display("FAIL rnd%0d_rem %h/%h got %h want %h", i, a, b, remainder, exp_r); else pass_cnt++;
      total_cnt++; if (div_zero !== (b == '0)) $display("FAIL rnd%0d_dz got %b want %b", i, div_zero, (b == '0)); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (done !== 1'b0) $display("FAIL rnd%0d_done_width got %b want 0", i, done); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
